dma_xfer: RTL and testbench
===========================

Name: dma_xfer

Overview:
- AHB-Lite master DMA engine. It is the responder to core_set's address/request interface.
- Accepts burst requests (address, size, direction, beat count) from core_set using the O_BUSY / I_DMA_READY handshake, then executes each as an INCR burst on AHB.
- Read data is staged in an internal FIFO. Later write bursts drain that FIFO back to memory, which completes the rotate read-then-write flow.

Parameters:
- DATA_W, 32: AHB data width.
- ADDR_W, 32: AHB address width.
- FIFO_DEPTH, 32: staging buffer depth in words. Must be >= 31.
- LVL_W, 6: FIFO level width, equal to clog2(FIFO_DEPTH)+1.

Ports:
- I_HCLK  in  1  clock.
- I_HRESET_N  in  1  asynchronous active-low reset.
- I_ADDR  in  ADDR_W  request start byte address (core_set O_ADDR).
- I_SIZE  in  3  HSIZE encoding (core_set O_SIZE).
- I_WRITE  in  1  1 = write burst, 0 = read burst.
- I_COUNT  in  5  beat count, 1..31 (core_set O_COUNT).
- I_BUSY  in  1  request valid (core_set O_BUSY).
- O_DMA_READY  out  1  engine idle; can accept a request.
- O_DONE  out  1  one-cycle pulse when a request completes or is rejected.
- O_ERR  out  1  sticky error flag; cleared only by reset.
- O_FIFO_LEVEL  out  LVL_W  FIFO occupancy.
- O_HADDR  out  ADDR_W  AHB address.
- O_HTRANS  out  2  AHB transfer type.
- O_HWRITE  out  1  AHB write.
- O_HSIZE  out  3  AHB size.
- O_HBURST  out  3  AHB burst type; constant 3'b001 (INCR).
- O_HWDATA  out  DATA_W  AHB write data.
- I_HRDATA  in  DATA_W  AHB read data.
- I_HREADY  in  1  AHB ready.
- I_HRESP  in  1  AHB response; 1 = ERROR.

Behaviour:
- Clocking and reset: single clock I_HCLK. I_HRESET_N is asynchronous and active-low. All outputs are registered.
- Reset values:
  - O_DMA_READY=1.
  - O_DONE=0, O_ERR=0, O_FIFO_LEVEL=0, O_HADDR=0, O_HTRANS=IDLE(00), O_HWRITE=0, O_HSIZE=0, O_HWDATA=0.
  - O_HBURST=001.
  - FIFO pointers cleared.
- Reset mid-burst: immediate abort. FIFO contents are discarded and no completion pulse is issued.
- States: IDLE, XFER (address phases outstanding), LAST (final data phase), DONE.
- Accept: on a rising edge with O_DMA_READY=1 and I_BUSY=1, capture I_ADDR, I_SIZE, I_WRITE, I_COUNT. O_DMA_READY=0 from the next cycle.
- Reject (evaluated at the accept edge, no bus activity):
  - Conditions: I_COUNT=0, or I_SIZE>2, or read with (FIFO_DEPTH - level) < I_COUNT, or write with level < I_COUNT.
  - I_COUNT=0 goes to DONE without setting O_ERR.
  - All other reject conditions go to DONE and set O_ERR.
- XFER:
  - The first address phase is driven in the cycle after accept: HTRANS=NONSEQ, HADDR=captured address, HSIZE=captured size, HWRITE=captured write.
  - Each subsequent beat is SEQ, with HADDR += (1 << size).
  - Address and control hold while I_HREADY=0.
  - After the last address phase is accepted, HTRANS=IDLE and the state moves to LAST.
- Write data:
  - The FIFO head is popped when a write address phase is accepted (I_HREADY=1).
  - O_HWDATA is loaded on that same edge, so it is valid in the following data phase and held while I_HREADY=0.
  - Full words are transferred unchanged; core_set owns byte-lane placement.
- Read data: I_HRDATA is pushed into the FIFO on each read data phase completing with I_HREADY=1 and I_HRESP=0.
- FIFO level:
  - O_FIFO_LEVEL updates the cycle after each push or pop.
  - Push and pop never occur in the same cycle, because a burst is single-direction.
- LAST: when the final data phase completes (I_HREADY=1), go to DONE.
- DONE: O_DONE=1 for one cycle. O_DMA_READY=1 in the same cycle. Next state is IDLE.
- Error response:
  - I_HRESP=1 during any data phase: drive HTRANS=IDLE on the next edge, set O_ERR, go to DONE.
  - Beats not yet completed are abandoned.
  - Read data from the errored beat is not pushed.
- Requests while busy: I_BUSY is ignored unless O_DMA_READY=1.
- Boundaries: core_set guarantees that no burst crosses a 1 KB boundary, and the engine does not split bursts.

Test Plan:
- Read burst: ADDR=0x1000, SIZE=2, COUNT=8, WRITE=0, zero-wait slave returns 0xA0..0xA7.
  - Required: HTRANS sequence NONSEQ, then 7×SEQ, then IDLE.
  - Required: HADDR 0x1000..0x101C in steps of 4; FIFO_LEVEL=8; one O_DONE pulse; O_DMA_READY returns to 1.
- Write burst following the read: ADDR=0x2000, COUNT=8, WRITE=1.
  - Required: HWDATA=0xA0..0xA7 in order, one per data phase, with HWRITE=1; FIFO_LEVEL=0 at DONE; O_ERR=0.
- Wait states: 4-beat read with HREADY low for 2 cycles on beat 2.
  - Required: HADDR and HTRANS held during the stall; exactly 4 pushes; 4-cycle-minimum burst stretched by 2 cycles.
- Rejects:
  - COUNT=0: O_DONE pulse, no HTRANS activity, O_ERR=0.
  - Write COUNT=5 with FIFO_LEVEL=3: O_DONE pulse, no bus activity, O_ERR=1.
  - SIZE=3: O_ERR=1.
- Error response: HRESP=1 on beat 3 of an 8-beat read.
  - Required: HTRANS=IDLE next cycle; FIFO_LEVEL=2; O_ERR=1 and sticky until reset.
- Reset mid-burst: assert I_HRESET_N=0 on beat 4 of a write burst.
  - Required: all outputs at reset values asynchronously, FIFO_LEVEL=0.
  - Required: a new request after deassertion is accepted normally.

Source files
------------

// File: rtl/dma_xfer.sv
// dma_xfer: AHB-Lite master burst engine. It accepts one request at a time and
// stages read data in an internal FIFO. Write bursts drain that FIFO back to memory.
module dma_xfer #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned LVL_W      = 6
) (
   input  logic              I_HCLK,
   input  logic              I_HRESET_N,
   input  logic [ADDR_W-1:0] I_ADDR,
   input  logic [2:0]        I_SIZE,
   input  logic              I_WRITE,
   input  logic [4:0]        I_COUNT,
   input  logic              I_BUSY,
   output logic              O_DMA_READY,
   output logic              O_DONE,
   output logic              O_ERR,
   output logic [LVL_W-1:0]  O_FIFO_LEVEL,
   output logic [ADDR_W-1:0] O_HADDR,
   output logic [1:0]        O_HTRANS,
   output logic              O_HWRITE,
   output logic [2:0]        O_HSIZE,
   output logic [2:0]        O_HBURST,
   output logic [DATA_W-1:0] O_HWDATA,
   input  logic [DATA_W-1:0] I_HRDATA,
   input  logic              I_HREADY,
   input  logic              I_HRESP
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {StIdle, StXfer, StLast, StDone} state_t;

   state_t              r_state, w_state_d;
   logic [ADDR_W-1:0]   r_haddr, w_haddr_d;
   logic [1:0]          r_htrans, w_htrans_d;
   logic                r_hwrite, w_hwrite_d;
   logic [2:0]          r_hsize, w_hsize_d;
   logic [DATA_W-1:0]   r_hwdata, w_hwdata_d;
   logic [4:0]          r_left, w_left_d;     // address phases still to issue
   logic                r_dph, w_dph_d;       // a data phase is outstanding
   logic                r_ready, w_ready_d;
   logic                r_done, w_done_d;
   logic                r_err, w_err_d;
   logic [LVL_W-1:0]    r_level, w_level_d;
   logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

   logic                w_push, w_pop;
   logic [DATA_W-1:0]   w_fifo_head;
   logic [LVL_W-1:0]    w_space, w_cnt;
   logic                w_rej_zero, w_rej_err;

   assign w_fifo_head = r_mem[r_rd_ptr];
   assign w_space     = LVL_W'(FIFO_DEPTH) - r_level;
   assign w_cnt       = LVL_W'(I_COUNT);
   assign w_rej_zero  = (I_COUNT == 5'd0);
   assign w_rej_err   = (I_SIZE > 3'd2) || (!I_WRITE && (w_space < w_cnt)) ||
                        (I_WRITE && (r_level < w_cnt));

   // Next-state, bus control and FIFO push/pop decisions.
   always_comb begin
      w_state_d  = r_state;
      w_haddr_d  = r_haddr;
      w_htrans_d = r_htrans;
      w_hwrite_d = r_hwrite;
      w_hsize_d  = r_hsize;
      w_hwdata_d = r_hwdata;
      w_left_d   = r_left;
      w_dph_d    = r_dph;
      w_ready_d  = r_ready;
      w_done_d   = 1'b0;
      w_err_d    = r_err;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      unique case (r_state)
         StXfer: begin
            if (r_dph && I_HRESP) begin
               // Error response: abandon the remaining beats.
               w_htrans_d = HTRANS_IDLE;
               w_dph_d    = 1'b0;
               w_err_d    = 1'b1;
               w_state_d  = StDone;
               w_done_d   = 1'b1;
               w_ready_d  = 1'b1;
            end else if (I_HREADY) begin
               w_push  = r_dph && !r_hwrite;
               w_dph_d = 1'b1;
               if (r_hwrite) begin
                  w_pop      = 1'b1;
                  w_hwdata_d = w_fifo_head;
               end
               if (r_left != 5'd0) begin
                  w_htrans_d = HTRANS_SEQ;
                  w_haddr_d  = r_haddr + (ADDR_W'(1) << r_hsize);
                  w_left_d   = r_left - 5'd1;
               end else begin
                  w_htrans_d = HTRANS_IDLE;
                  w_state_d  = StLast;
               end
            end
         end
         StLast: begin
            if (I_HRESP) begin
               w_dph_d   = 1'b0;
               w_err_d   = 1'b1;
               w_state_d = StDone;
               w_done_d  = 1'b1;
               w_ready_d = 1'b1;
            end else if (I_HREADY) begin
               w_push    = !r_hwrite;
               w_dph_d   = 1'b0;
               w_state_d = StDone;
               w_done_d  = 1'b1;
               w_ready_d = 1'b1;
            end
         end
         StIdle, StDone: w_state_d = StIdle;
         default:        w_state_d = StIdle;
      endcase
      // Accept is only possible in IDLE/DONE, where nothing above touches the bus.
      if (r_ready && I_BUSY) begin
         if (w_rej_zero || w_rej_err) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
            w_ready_d = 1'b1;
            w_err_d   = r_err | w_rej_err;
         end else begin
            w_state_d  = StXfer;
            w_ready_d  = 1'b0;
            w_htrans_d = HTRANS_NONSEQ;
            w_haddr_d  = I_ADDR;
            w_hsize_d  = I_SIZE;
            w_hwrite_d = I_WRITE;
            w_left_d   = I_COUNT - 5'd1;
            w_dph_d    = 1'b0;
         end
      end
   end

   always_comb begin
      w_level_d = r_level;
      if (w_push) begin
         w_level_d = r_level + LVL_W'(1);
      end else if (w_pop) begin
         w_level_d = r_level - LVL_W'(1);
      end
   end

   // State and registered outputs; reset discards FIFO contents.
   always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
      if (!I_HRESET_N) begin
         r_state  <= StIdle;
         r_haddr  <= '0;
         r_htrans <= HTRANS_IDLE;
         r_hwrite <= 1'b0;
         r_hsize  <= 3'd0;
         r_hwdata <= '0;
         r_left   <= 5'd0;
         r_dph    <= 1'b0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_level  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_state  <= w_state_d;
         r_haddr  <= w_haddr_d;
         r_htrans <= w_htrans_d;
         r_hwrite <= w_hwrite_d;
         r_hsize  <= w_hsize_d;
         r_hwdata <= w_hwdata_d;
         r_left   <= w_left_d;
         r_dph    <= w_dph_d;
         r_ready  <= w_ready_d;
         r_done   <= w_done_d;
         r_err    <= w_err_d;
         r_level  <= w_level_d;
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
      end
   end

   // Staging storage; contents need no reset because the pointers gate them.
   always_ff @(posedge I_HCLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= I_HRDATA;
      end
   end

   assign O_DMA_READY  = r_ready;
   assign O_DONE       = r_done;
   assign O_ERR        = r_err;
   assign O_FIFO_LEVEL = r_level;
   assign O_HADDR      = r_haddr;
   assign O_HTRANS     = r_htrans;
   assign O_HWRITE     = r_hwrite;
   assign O_HSIZE      = r_hsize;
   assign O_HBURST     = 3'b001;
   assign O_HWDATA     = r_hwdata;

endmodule

// File: tb/tb_dma_xfer.sv
// tb_dma_xfer: scoreboard bench with an AHB slave model for dma_xfer.
module tb_dma_xfer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int FIFO_DEPTH = 32;
   localparam int LVL_W = 6;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] i_addr;
   logic [2:0]        i_size;
   logic              i_write;
   logic [4:0]        i_count;
   logic              i_busy;
   logic              o_dma_ready, o_done, o_err;
   logic [LVL_W-1:0]  o_fifo_level;
   logic [ADDR_W-1:0] o_haddr;
   logic [1:0]        o_htrans;
   logic              o_hwrite;
   logic [2:0]        o_hsize, o_hburst;
   logic [DATA_W-1:0] o_hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready, hresp;

   dma_xfer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
   ) u_dut (
      .I_HCLK(clk), .I_HRESET_N(rst_n), .I_ADDR(i_addr), .I_SIZE(i_size),
      .I_WRITE(i_write), .I_COUNT(i_count), .I_BUSY(i_busy),
      .O_DMA_READY(o_dma_ready), .O_DONE(o_done), .O_ERR(o_err),
      .O_FIFO_LEVEL(o_fifo_level), .O_HADDR(o_haddr), .O_HTRANS(o_htrans),
      .O_HWRITE(o_hwrite), .O_HSIZE(o_hsize), .O_HBURST(o_hburst), .O_HWDATA(o_hwdata),
      .I_HRDATA(hrdata), .I_HREADY(hready), .I_HRESP(hresp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
   } exp_addr_t;

   exp_addr_t   exp_addr[$];
   logic [31:0] exp_wdata[$];
   logic [31:0] mdl_fifo[$];

   int cmp_cnt = 0;
   int mis_cnt = 0;

   // Slave/monitor state (written by the monitor only) and test knobs (main only).
   bit          dph, dwrite, hold_pend, m_rdy, m_rsp;
   int          abeat, dbeat, stall_done;
   logic [31:0] hold_addr;
   logic [1:0]  hold_trans;
   exp_addr_t   m_e;
   logic [31:0] m_w;
   int          err_beat, stall_beat, stall_cycles;
   logic [31:0] rdata_base;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      if (obs !== exp) begin
         mis_cnt++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // AHB slave plus address/data scoreboard; decides the coming edge at each negedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         dph = 1'b0;
         hold_pend = 1'b0;
         hready = 1'b1;
         hresp = 1'b0;
         hrdata = '0;
      end else begin
         if (hold_pend) begin
            check_val("haddr_hold", o_haddr, hold_addr);
            check_val("htrans_hold", o_htrans, hold_trans);
         end
         hold_pend = 1'b0;
         m_rdy = 1'b1;
         m_rsp = 1'b0;
         if (dph) begin
            if (err_beat != 0 && dbeat == err_beat) begin
               m_rdy = 1'b0;
               m_rsp = 1'b1;
            end else if (stall_beat != 0 && dbeat == stall_beat && stall_done < stall_cycles) begin
               m_rdy = 1'b0;
               stall_done++;
            end
         end
         hready = m_rdy;
         hresp = m_rsp;
         hrdata = dph ? rdata_base + 32'(dbeat - 1) : '0;
         if (exp_addr.size() == 0 && !m_rsp) check_val("htrans_idle", o_htrans, 2'b00);
         if (dph && m_rdy) begin
            if (!dwrite) begin
               mdl_fifo.push_back(hrdata);
            end else if (exp_wdata.size() == 0) begin
               check_val("wdata_expected", 0, 1);
            end else begin
               m_w = exp_wdata.pop_front();
               check_val("hwdata", o_hwdata, m_w);
               check_val("hwrite", o_hwrite, 1);
            end
         end
         if (m_rdy && o_htrans != 2'b00) begin
            if (o_htrans == 2'b10) begin
               abeat = 0;
               stall_done = 0;
            end
            abeat++;
            if (exp_addr.size() != 0) begin
               m_e = exp_addr.pop_front();
               check_val("haddr", o_haddr, m_e.addr);
               check_val("htrans", o_htrans, m_e.trans);
            end
            dbeat = abeat;
            dwrite = o_hwrite;
            dph = 1'b1;
         end else if (m_rdy || m_rsp) begin
            dph = 1'b0;
         end
         if (!m_rdy && !m_rsp && o_htrans != 2'b00) begin
            hold_pend = 1'b1;
            hold_addr = o_haddr;
            hold_trans = o_htrans;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ready"}, o_dma_ready, 1);
      check_val({tag, "_done"}, o_done, 0);
      check_val({tag, "_err"}, o_err, 0);
      check_val({tag, "_level"}, o_fifo_level, 0);
      check_val({tag, "_haddr"}, o_haddr, 0);
      check_val({tag, "_htrans"}, o_htrans, 0);
      check_val({tag, "_hwrite"}, o_hwrite, 0);
      check_val({tag, "_hsize"}, o_hsize, 0);
      check_val({tag, "_hwdata"}, o_hwdata, 0);
      check_val({tag, "_hburst"}, o_hburst, 3'b001);
   endtask

   task automatic clear_model();
      exp_addr.delete();
      exp_wdata.delete();
      mdl_fifo.delete();
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(tag);
      clear_model();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one request; queue expectations first, then optionally wait for O_DONE.
   task automatic do_req(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic wr, input logic [4:0] count, input logic [31:0] rbase,
                         input int sbeat, input int scyc, input int ebeat,
                         input logic exp_err, input int exp_level, input bit wait_done);
      bit rej, found;
      int n, n_addr, exp_edges;
      exp_addr_t e;
      rej = (count == 0) || (size > 3'd2) ||
            (!wr && (FIFO_DEPTH - mdl_fifo.size()) < int'(count)) ||
            (wr && mdl_fifo.size() < int'(count));
      n_addr = rej ? 0 : ((ebeat != 0) ? ebeat : int'(count));
      exp_edges = rej ? 0 : ((ebeat != 0) ? ebeat + 1 : int'(count) + 1 + scyc);
      for (int i = 0; i < n_addr; i++) begin
         e.addr = addr + 32'(i * (1 << size));
         e.trans = (i == 0) ? 2'b10 : 2'b11;
         exp_addr.push_back(e);
      end
      if (wr && !rej) begin
         for (int i = 0; i < int'(count); i++) exp_wdata.push_back(mdl_fifo.pop_front());
      end
      err_beat = ebeat;
      stall_beat = sbeat;
      stall_cycles = scyc;
      rdata_base = rbase;
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (o_dma_ready) begin
            found = 1'b1;
            break;
         end
      end
      check_val({tag, "_ready_before"}, found, 1);
      i_addr = addr;
      i_size = size;
      i_write = wr;
      i_count = count;
      i_busy = 1'b1;
      @(posedge clk);
      #1 i_busy = 1'b0;
      if (wait_done) begin
         found = 1'b0;
         n = 0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_done) begin
               found = 1'b1;
               n = k;
               break;
            end
         end
         check_val({tag, "_done_seen"}, found, 1);
         check_val({tag, "_latency"}, n, exp_edges);
         check_val({tag, "_err"}, o_err, exp_err);
         check_val({tag, "_level"}, o_fifo_level, exp_level);
         check_val({tag, "_ready_at_done"}, o_dma_ready, 1);
         check_val({tag, "_addr_left"}, exp_addr.size(), 0);
         check_val({tag, "_wdata_left"}, exp_wdata.size(), 0);
         @(negedge clk);
         check_val({tag, "_done_pulse"}, o_done, 0);
         check_val({tag, "_idle_htrans"}, o_htrans, 0);
      end
   endtask

   initial begin
      bit hit;
      i_busy = 1'b0;
      i_addr = '0;
      i_size = '0;
      i_write = 1'b0;
      i_count = '0;
      err_beat = 0;
      stall_beat = 0;
      stall_cycles = 0;
      rdata_base = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst");
      @(negedge clk) rst_n = 1'b1;

      do_req("rd8", 32'h1000, 3'd2, 1'b0, 5'd8, 32'hA0, 0, 0, 0, 1'b0, 8, 1'b1);
      do_req("wr8", 32'h2000, 3'd2, 1'b1, 5'd8, 32'h0, 0, 0, 0, 1'b0, 0, 1'b1);
      do_req("rd4_wait", 32'h3000, 3'd2, 1'b0, 5'd4, 32'hB0, 2, 2, 0, 1'b0, 4, 1'b1);
      do_req("rej_cnt0", 32'h3100, 3'd2, 1'b0, 5'd0, 32'h0, 0, 0, 0, 1'b0, 4, 1'b1);
      do_req("wr1", 32'h4000, 3'd2, 1'b1, 5'd1, 32'h0, 0, 0, 0, 1'b0, 3, 1'b1);
      do_req("rej_wr5", 32'h4100, 3'd2, 1'b1, 5'd5, 32'h0, 0, 0, 0, 1'b1, 3, 1'b1);
      do_req("rej_size3", 32'h4200, 3'd3, 1'b0, 5'd2, 32'h0, 0, 0, 0, 1'b1, 3, 1'b1);

      pulse_reset("rst2");
      do_req("rd8_err", 32'h5000, 3'd2, 1'b0, 5'd8, 32'hC0, 0, 0, 3, 1'b1, 2, 1'b1);
      do_req("rd4_sticky", 32'h5100, 3'd2, 1'b0, 5'd4, 32'hD0, 0, 0, 0, 1'b1, 6, 1'b1);

      pulse_reset("rst3");
      do_req("rd8_b", 32'h6000, 3'd2, 1'b0, 5'd8, 32'hE0, 0, 0, 0, 1'b0, 8, 1'b1);
      do_req("wr8_abort", 32'h7000, 3'd2, 1'b1, 5'd8, 32'h0, 0, 0, 0, 1'b0, 0, 1'b0);
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #2;
         if (abeat >= 4) begin
            hit = 1'b1;
            break;
         end
      end
      check_val("abort_beat4_reached", hit, 1);
      rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      do_req("rd2_after", 32'h8000, 3'd2, 1'b0, 5'd2, 32'hF0, 0, 0, 0, 1'b0, 2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

endmodule
